mem_access_unit: RTL and testbench
==================================

# mem_access_unit

Initiator side of the 20-bit word RAM port. It turns single load/store requests from the CPU datapath, plus block copy and block fill commands, into the RAM's `addr`/`write`/`str`/`ld` signals and returns read data. It sits between the control unit/datapath and `ram`. It is the only driver of the RAM port, and it guarantees that `str` and `ld` are never asserted together.

## Interface
Parameters:
- `AW`, 10, word-address width (1024 words)
- `DW`, 20, data word width

Ports (clock and reset first):
- `clk` in 1: rising-edge clock shared with `ram`
- `rst` in 1: asynchronous, active-high reset
- `req` in 1: command strobe, sampled only when `busy`=0
- `op` in 2: command; 00 load, 01 store, 10 copy, 11 fill
- `addr` in AW: load/store address; copy source
- `dst` in AW: copy/fill destination
- `len` in AW: copy/fill word count (0..1023)
- `wdata` in DW: store data; fill value
- `busy` out 1: command in progress
- `done` out 1: one-cycle completion pulse
- `rdata` out DW: last word read from RAM
- `ram_addr` out AW, `ram_write` out DW, `ram_str` out 1, `ram_ld` out 1: RAM port drives
- `ram_read` in DW: RAM read data

## Operation
- RAM contract:
  - Write occurs at the rising edge that ends a cycle with `ram_str`=1.
  - Read data is valid within a cycle that has `ram_ld`=1 and a stable `ram_addr`. This block captures it at the edge that ends that cycle.
- FSM states: IDLE, LOAD, STORE, CP_RD, CP_WR, FILL.
- IDLE:
  - `req`=1 at an edge latches op/addr/dst/len/wdata into internal registers `src`, `dp`, `cnt`, `val`.
  - op 00 -> LOAD; 01 -> STORE.
  - op 10 -> CP_RD if `len`≠0, else stay IDLE with `done`=1 next cycle.
  - op 11 -> FILL if `len`≠0, else the same zero-length completion.
- LOAD: `ram_ld`=1, `ram_addr`=src. At the closing edge: `rdata`<=`ram_read`, go to IDLE, `done`=1.
- STORE: `ram_str`=1, `ram_addr`=src, `ram_write`=val. At the closing edge go to IDLE, `done`=1.
- CP_RD: `ram_ld`=1, `ram_addr`=src. At the closing edge: `rdata`<=`ram_read`, src<=src+1, go to CP_WR.
- CP_WR:
  - `ram_str`=1, `ram_addr`=dp, `ram_write`=rdata.
  - At the closing edge: dp<=dp+1, cnt<=cnt-1.
  - If cnt was 1, go to IDLE with `done`=1; else go to CP_RD.
- FILL:
  - `ram_str`=1, `ram_addr`=dp, `ram_write`=val every cycle.
  - At each edge: dp+1, cnt-1. Exit to IDLE with `done`=1 when cnt was 1.
- Address arithmetic is modulo 2^AW: 1023+1 -> 0, with no error flag.
- Copy is strictly forward, one word at a time. Overlapping ranges (e.g. dst=src+1) replicate the first word; this is the defined behaviour.
- In IDLE, `ram_str`=`ram_ld`=0, `ram_addr`=0 and `ram_write`=0. RAM drives are a combinational decode of state and registers.
- `req` while `busy`=1 is ignored. It is not queued.

## Timing
- Reset values: `busy`=0, `done`=0, `rdata`=0, `ram_str`=0, `ram_ld`=0, `ram_addr`=0, `ram_write`=0, state IDLE.
- `rst` takes effect immediately. Asserting it mid-command drops `ram_str` in the same cycle; the pending write and all remaining words are abandoned.
- `busy` is 1 exactly while state≠IDLE. `done` is a registered pulse in the first IDLE cycle after completion, when `busy`=0.
- A new `req` is accepted on the edge that ends the `done` cycle.
- Command latencies, counted from the edge that samples `req` to `done`=1:
  - load: 2 edges; `rdata` is valid in the `done` cycle and holds until the next read.
  - store: 2 edges.
  - copy: 2·len+1 edges.
  - fill: len+1 edges.
  - len=0: 1 edge, with no RAM access.
- One RAM access per cycle, and `ram_str`·`ram_ld` is always 0.

## Test plan
- Reset, then RAM preloaded with word0=0xABCDE; load addr 0 -> `ram_ld` high for 1 cycle, `done` 2 edges after `req`, `rdata`=0xABCDE.
- Store wdata=101 at addr 1, then load addr 1 -> `ram_str` high for exactly 1 cycle, `rdata`=0x00065; `ram_str` and `ram_ld` never both high.
- Fill dst=1020, len=6, wdata=0x12345 -> words 1020..1023, 0 and 1 equal 0x12345; `busy` for 6 cycles; `done` on the 7th edge; word 2 unchanged.
- Preload words 0..2 with 0xABCDE, 0x00065, 0x000CA; copy src=0, dst=8, len=3 -> `ld`/`str` alternate over 6 cycles; words 8..10 match; `rdata`=0x000CA at `done`.
- Pulse `req` (store) during a copy -> ignored, no extra `ram_str`. Copy with len=0 -> `done` after 1 edge, `busy` never high, no RAM strobes.
- Fill len=10, assert `rst` after the 3rd write -> `ram_str`/`busy` drop in the same cycle; only 3 words are written; `rdata`=0.

Source files
------------

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - initiator for the 20-bit word RAM port
// Executes single load/store and block copy/fill commands, one RAM access per cycle.
module mem_access_unit #(
    parameter int AW = 10,
    parameter int DW = 20
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req,
    input  logic [1:0]    op,
    input  logic [AW-1:0] addr,
    input  logic [AW-1:0] dst,
    input  logic [AW-1:0] len,
    input  logic [DW-1:0] wdata,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] rdata,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_write,
    output logic          ram_str,
    output logic          ram_ld,
    input  logic [DW-1:0] ram_read
);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_STORE, S_CP_RD, S_CP_WR, S_FILL
    } state_t;

    localparam logic [AW-1:0] ONE = AW'(1);

    state_t        r_state;
    state_t        w_next;
    logic          w_finish;
    logic [AW-1:0] r_src;
    logic [AW-1:0] r_dp;
    logic [AW-1:0] r_cnt;
    logic [DW-1:0] r_val;
    logic [DW-1:0] r_rdata;
    logic          r_done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // w_finish marks the last edge of a command; done is its registered copy
    always_comb begin
        w_next   = r_state;
        w_finish = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (req) begin
                    case (op)
                        2'b00: w_next = S_LOAD;
                        2'b01: w_next = S_STORE;
                        2'b10: begin
                            if (len != '0) w_next = S_CP_RD;
                            else           w_finish = 1'b1;
                        end
                        default: begin
                            if (len != '0) w_next = S_FILL;
                            else           w_finish = 1'b1;
                        end
                    endcase
                end
            end
            S_LOAD, S_STORE: begin
                w_next   = S_IDLE;
                w_finish = 1'b1;
            end
            S_CP_RD: w_next = S_CP_WR;
            S_CP_WR: begin
                if (r_cnt == ONE) begin
                    w_next   = S_IDLE;
                    w_finish = 1'b1;
                end else begin
                    w_next = S_CP_RD;
                end
            end
            S_FILL: begin
                if (r_cnt == ONE) begin
                    w_next   = S_IDLE;
                    w_finish = 1'b1;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy      = (r_state != S_IDLE);
        ram_addr  = '0;
        ram_write = '0;
        ram_str   = 1'b0;
        ram_ld    = 1'b0;
        case (r_state)
            S_LOAD, S_CP_RD: begin
                ram_ld   = 1'b1;
                ram_addr = r_src;
            end
            S_STORE: begin
                ram_str   = 1'b1;
                ram_addr  = r_src;
                ram_write = r_val;
            end
            S_CP_WR: begin
                ram_str   = 1'b1;
                ram_addr  = r_dp;
                ram_write = r_rdata;
            end
            S_FILL: begin
                ram_str   = 1'b1;
                ram_addr  = r_dp;
                ram_write = r_val;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_src   <= '0;
            r_dp    <= '0;
            r_cnt   <= '0;
            r_val   <= '0;
            r_rdata <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= w_finish;
            case (r_state)
                S_IDLE: begin
                    if (req) begin
                        r_src <= addr;
                        r_dp  <= dst;
                        r_cnt <= len;
                        r_val <= wdata;
                    end
                end
                S_LOAD: r_rdata <= ram_read;
                S_CP_RD: begin
                    r_rdata <= ram_read;
                    r_src   <= r_src + ONE;
                end
                S_CP_WR, S_FILL: begin
                    r_dp  <= r_dp + ONE;
                    r_cnt <= r_cnt - ONE;
                end
                default: ;
            endcase
        end
    end

    assign done  = r_done;
    assign rdata = r_rdata;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - self-checking bench for mem_access_unit
// Command-level model produces the expected per-cycle port trace and RAM image.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic [1:0]  op = '0;
    logic [9:0]  addr = '0, dst = '0, len = '0;
    logic [19:0] wdata = '0;
    logic        busy, done;
    logic [19:0] rdata;
    logic [9:0]  ram_addr;
    logic [19:0] ram_write, ram_read;
    logic        ram_str, ram_ld;

    mem_access_unit #(.AW(10), .DW(20)) dut (
        .clk(clk), .rst(rst), .req(req), .op(op), .addr(addr), .dst(dst),
        .len(len), .wdata(wdata), .busy(busy), .done(done), .rdata(rdata),
        .ram_addr(ram_addr), .ram_write(ram_write), .ram_str(ram_str),
        .ram_ld(ram_ld), .ram_read(ram_read)
    );

    always #5 clk = ~clk;

    logic [19:0] ram [1024];
    logic        mem_clr = 1'b1;
    logic        pl_en = 1'b0;
    logic [9:0]  pl_addr = '0;
    logic [19:0] pl_data = '0;

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 1024; i++) ram[i] <= '0;
        end else if (pl_en) begin
            ram[pl_addr] <= pl_data;
        end else if (ram_str) begin
            ram[ram_addr] <= ram_write;
        end
    end
    assign ram_read = ram[ram_addr];

    typedef struct {
        logic        busy, done, str, ld;
        logic [9:0]  addr;
        logic [19:0] wr, rd;
    } rec_t;

    rec_t        exp_q[$];
    logic [19:0] m_mem [1024];
    logic [19:0] m_rdata = '0;
    int          n_cmp = 0;
    int          n_bad = 0;
    logic        chk_en = 1'b0;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endfunction

    function automatic void push(input logic b, d, s, l, input logic [9:0] a, input logic [19:0] w);
        rec_t r;
        r.busy = b; r.done = d; r.str = s; r.ld = l;
        r.addr = a; r.wr = w; r.rd = m_rdata;
        exp_q.push_back(r);
    endfunction

    always @(negedge clk) begin
        if (!rst && chk_en) begin
            rec_t e;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
            end else begin
                e.busy = 0; e.done = 0; e.str = 0; e.ld = 0;
                e.addr = '0; e.wr = '0; e.rd = m_rdata;
            end
            chk("busy", 32'(busy), 32'(e.busy));
            chk("done", 32'(done), 32'(e.done));
            chk("ram_str", 32'(ram_str), 32'(e.str));
            chk("ram_ld", 32'(ram_ld), 32'(e.ld));
            chk("ram_addr", 32'(ram_addr), 32'(e.addr));
            chk("ram_write", 32'(ram_write), 32'(e.wr));
            chk("rdata", 32'(rdata), 32'(e.rd));
            chk("str_ld_excl", 32'(ram_str & ram_ld), 32'd0);
        end
    end

    task automatic preload(input logic [9:0] a, input logic [19:0] v);
        @(posedge clk); #1;
        pl_en = 1'b1; pl_addr = a; pl_data = v;
        m_mem[a] = v;
        @(posedge clk); #1;
        pl_en = 1'b0;
    endtask

    // Issue one command; the model appends the cycles it must produce.
    // limit truncates a fill for the reset-abort case (no done record).
    task automatic cmd(input logic [1:0] o, input logic [9:0] a, d, n,
                       input logic [19:0] v, input int limit);
        @(posedge clk); #1;
        req = 1'b1; op = o; addr = a; dst = d; len = n; wdata = v;
        push(0, 0, 0, 0, '0, '0);
        case (o)
            2'b00: begin
                push(1, 0, 0, 1, a, '0);
                m_rdata = m_mem[a];
                push(0, 1, 0, 0, '0, '0);
            end
            2'b01: begin
                push(1, 0, 1, 0, a, v);
                m_mem[a] = v;
                push(0, 1, 0, 0, '0, '0);
            end
            2'b10: begin
                for (int i = 0; i < int'(n); i++) begin
                    logic [9:0] sa, da;
                    sa = a + 10'(i);
                    da = d + 10'(i);
                    push(1, 0, 0, 1, sa, '0);
                    m_rdata = m_mem[sa];
                    push(1, 0, 1, 0, da, m_rdata);
                    m_mem[da] = m_rdata;
                end
                push(0, 1, 0, 0, '0, '0);
            end
            default: begin
                for (int i = 0; i < int'(n) && i < limit; i++) begin
                    logic [9:0] da;
                    da = d + 10'(i);
                    push(1, 0, 1, 0, da, v);
                    m_mem[da] = v;
                end
                if (limit >= int'(n)) push(0, 1, 0, 0, '0, '0);
            end
        endcase
        @(posedge clk); #1;
        req = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 5000 && exp_q.size() != 0; i++) @(posedge clk);
        if (exp_q.size() != 0) begin
            n_cmp++; n_bad++;
            $display("FAIL drain_timeout: %0d cycles still expected, required 0", exp_q.size());
            exp_q.delete();
        end
        @(posedge clk);
    endtask

    initial begin
        int diffs;
        for (int i = 0; i < 1024; i++) m_mem[i] = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_rdata", 32'(rdata), 0);
        chk("rst_str", 32'(ram_str), 0);
        chk("rst_ld", 32'(ram_ld), 0);
        chk("rst_addr", 32'(ram_addr), 0);
        chk("rst_write", 32'(ram_write), 0);
        rst = 1'b0; mem_clr = 1'b0;
        chk_en = 1'b1;

        preload(10'd0, 20'hABCDE);
        cmd(2'b00, 10'd0, 10'd0, 10'd0, 20'd0, 0);
        drain();
        chk("load0_rdata", 32'(rdata), 32'h000ABCDE);
        chk("model_load0", 32'(m_rdata), 32'h000ABCDE);

        cmd(2'b01, 10'd1, 10'd0, 10'd0, 20'd101, 0);
        drain();
        cmd(2'b00, 10'd1, 10'd0, 10'd0, 20'd0, 0);
        drain();
        chk("load1_rdata", 32'(rdata), 32'h00065);

        cmd(2'b11, 10'd0, 10'd1020, 10'd6, 20'h12345, 1024);
        drain();
        chk("fill_1020", 32'(ram[1020]), 32'h12345);
        chk("fill_1023", 32'(ram[1023]), 32'h12345);
        chk("fill_0", 32'(ram[0]), 32'h12345);
        chk("fill_1", 32'(ram[1]), 32'h12345);
        chk("fill_2_kept", 32'(ram[2]), 32'h0);

        preload(10'd0, 20'hABCDE);
        preload(10'd1, 20'h00065);
        preload(10'd2, 20'h000CA);
        cmd(2'b10, 10'd0, 10'd8, 10'd3, 20'd0, 0);
        drain();
        chk("copy_8", 32'(ram[8]), 32'hABCDE);
        chk("copy_9", 32'(ram[9]), 32'h00065);
        chk("copy_10", 32'(ram[10]), 32'h000CA);
        chk("copy_rdata", 32'(rdata), 32'h000CA);

        // overlapping copy with a store request pulsed mid-command
        cmd(2'b10, 10'd8, 10'd9, 10'd3, 20'd0, 0);
        @(posedge clk); #1;
        req = 1'b1; op = 2'b01; addr = 10'd5; wdata = 20'd7;
        @(posedge clk); #1;
        req = 1'b0;
        drain();
        chk("ovl_11", 32'(ram[11]), 32'hABCDE);
        chk("ignored_store", 32'(ram[5]), 32'h0);

        cmd(2'b10, 10'd0, 10'd50, 10'd0, 20'd0, 0);
        drain();
        cmd(2'b11, 10'd0, 10'd60, 10'd0, 20'h11111, 0);
        drain();
        chk("len0_fill", 32'(ram[60]), 32'h0);

        cmd(2'b11, 10'd0, 10'd100, 10'd10, 20'h55555, 3);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        exp_q.delete();
        m_rdata = '0;
        #1;
        chk("abort_str", 32'(ram_str), 0);
        chk("abort_busy", 32'(busy), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("abort_rdata", 32'(rdata), 0);
        chk("abort_102", 32'(ram[102]), 32'h55555);
        chk("abort_103", 32'(ram[103]), 32'h0);

        diffs = 0;
        for (int i = 0; i < 1024; i++) if (ram[i] !== m_mem[i]) diffs++;
        chk("mem_image_diffs", 32'(diffs), 0);

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
